sync_fifo_rd_stream: RTL and testbench
======================================

Name: sync_fifo_rd_stream

Overview:
- Read-side engine for synchronous_fifo_3-style FIFOs: issues r_en pops against the FIFO's empty flag and absorbs the FIFO's 1-cycle read latency.
- Presents popped words as a valid/ready stream.
- Sits between a synchronous FIFO's read port and any downstream consumer, replacing hand-driven r_en toggling.
- Sustains 1 word/clk when the FIFO is non-empty and downstream is ready.

Parameters:
DATA_WIDTH, 8, width of FIFO data and stream data
CNT_WIDTH, 16, width of transferred-word counter
BURST_LEN, 4, words per burst for m_last (optional feature only)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  read enable; low stops issuing new pops
fifo_empty  input  1  FIFO empty flag
fifo_r_en  output  1  FIFO read strobe
fifo_data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_r_en
m_valid  output  1  stream data valid
m_ready  input  1  downstream accept
m_data  output  DATA_WIDTH  stream data
m_last  output  1  last word of burst (tied 0 without optional feature)
xfer_count  output  CNT_WIDTH  words accepted downstream, wraps
busy  output  1  occ!=0 or read in flight

Behaviour:
- Reset (async, active-high): occ=0, inflight=0, head/tail=0, xfer_count=0, burst counter=0. Outputs fifo_r_en=0, m_valid=0, m_data=0, m_last=0, busy=0.
- Reset mid-operation discards any in-flight word and all buffered words; nothing is emitted after release until a new pop completes.
- Internal 2-entry skid buffer: occ in 0..2, head/tail 1-bit pointers wrapping 1->0.
- pop_out = m_valid & m_ready.
- fifo_r_en (combinational) = en & !fifo_empty & ((occ + inflight - pop_out) < 2).
  - Never asserted while fifo_empty=1.
  - Never asserted when it would overflow the buffer.
- inflight: register loaded with fifo_r_en each cycle.
- When inflight=1, fifo_data_out is written to buf[tail] at the next edge; tail toggles.
- m_valid = (occ != 0). m_data = buf[head]. On pop_out, head toggles.
- occ_next = occ + inflight - pop_out. Simultaneous capture and pop leaves occ unchanged.
- Stream rules:
  - m_data and m_valid hold stable while m_valid & !m_ready.
  - m_valid never drops without a handshake, except on reset.
- Latency: FIFO goes non-empty at edge N, with en=1 and occ=0 → fifo_r_en high in cycle N → m_valid high after edge N+2 (2-cycle latency).
- Throughput: m_ready held 1 with the FIFO continuously non-empty → one word per clock, fifo_r_en continuously high.
- en deassert: pops stop the same cycle; an in-flight word is still captured; buffered words keep draining.
- Downstream stall (m_ready=0): at most 2 words buffered; fifo_r_en drops once occ + inflight reaches 2. No data loss, no FIFO underflow.
- xfer_count increments by 1 on each pop_out; wraps 2^CNT_WIDTH-1 → 0.
- busy = (occ != 0) | inflight.

Optional Feature:
- Macro: SYNC_FIFO_RD_STREAM_LAST_EN
- Defined:
  - Burst counter (width clog2(BURST_LEN)) increments on pop_out, wraps at BURST_LEN-1 → 0.
  - m_last = m_valid & (burst counter == BURST_LEN-1).
  - m_last is stable with m_data during a stall.
  - Counter resets to 0 on rst.
- Undefined: m_last tied to 0; no burst counter logic.

Test Plan:
- Reset check: assert rst during the first cycles with the FIFO holding 3 words. Required: fifo_r_en=0, m_valid=0, xfer_count=0 throughout reset, and no stale word emitted after release.
- Basic order: FIFO preloaded with 8 $random words, en=1, m_ready=1. Required: m_data sequence matches write order exactly, one word per clock, xfer_count=8, busy=0 afterwards.
- Backpressure: preload 8, m_ready toggled 1,0,1,0. Required:
  - all 8 words delivered in order, none duplicated;
  - m_data stable while stalled;
  - fifo_r_en never asserted with occ+inflight=2.
- Empty boundary: single word 0xA5 written, en=1. Required:
  - exactly one fifo_r_en pulse;
  - m_valid high 2 cycles later with m_data=0xA5;
  - fifo_r_en stays 0 while fifo_empty=1.
- en gating: en dropped the same cycle as a pop. Required: in-flight word still delivered; no further fifo_r_en until en=1.
- Optional feature, macro defined, BURST_LEN=4, 8 words streamed: m_last high on words 4 and 8 only. With the macro undefined, m_last stays 0.

Source files
------------

// File: rtl/sync_fifo_rd_stream_if.sv
// FIFO read-port and output-stream signals of sync_fifo_rd_stream.
// master = the stream engine, slave = the FIFO/consumer environment.
interface sync_fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  en;
  logic                  fifo_empty;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [CNT_WIDTH-1:0]  xfer_count;
  logic                  busy;

  modport master (
    input  en, fifo_empty, fifo_data_out, m_ready,
    output fifo_r_en, m_valid, m_data, m_last, xfer_count, busy
  );

  modport slave (
    output en, fifo_empty, fifo_data_out, m_ready,
    input  fifo_r_en, m_valid, m_data, m_last, xfer_count, busy
  );
endinterface

// File: rtl/sync_fifo_rd_stream.sv
// Pops a 1-cycle-latency sync FIFO into a valid/ready stream: 2 cycles pop-to-valid, 1 word/clk sustained.
// A 2-entry skid buffer absorbs m_ready stalls; m_last bursts enabled by SYNC_FIFO_RD_STREAM_LAST_EN.
module sync_fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sync_fifo_rd_stream_if.master bus
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic                  head_q, tail_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [CNT_WIDTH-1:0]  xfer_q;
  logic                  pop_out;
  logic [2:0]            level;

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("BURST_LEN must be at least 1");
  end

  assign pop_out = bus.m_valid & bus.m_ready;

  // Words owed to the buffer after this edge; a pop is only issued if it still fits.
  assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_out};
  assign occ_d = level[1:0];

  assign bus.fifo_r_en  = ~rst & bus.en & ~bus.fifo_empty & (level < 3'd2);
  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.m_data     = buf_q[head_q];
  assign bus.xfer_count = xfer_q;
  assign bus.busy       = (occ_q != 2'd0) | inflight_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      xfer_q     <= '0;
    end else begin
      inflight_q <= bus.fifo_r_en;
      occ_q      <= occ_d;
      if (inflight_q) begin
        buf_q[tail_q] <= bus.fifo_data_out;
        tail_q        <= ~tail_q;
      end
      if (pop_out) begin
        head_q <= ~head_q;
        xfer_q <= xfer_q + CNT_WIDTH'(1);
      end
    end
  end

`ifdef SYNC_FIFO_RD_STREAM_LAST_EN
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);

  logic [BW-1:0] burst_q;

  // Counter only moves on a handshake, so m_last stays aligned with m_data through stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q <= '0;
    end else if (pop_out) begin
      burst_q <= (burst_q == LAST_IDX) ? '0 : burst_q + BW'(1);
    end
  end

  assign bus.m_last = bus.m_valid & (burst_q == LAST_IDX);
`else
  assign bus.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Directed bench for sync_fifo_rd_stream: behavioural 1-cycle-latency FIFO plus an
// in-order scoreboard and per-cycle stream/flow-control checks.
module tb_sync_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_rd_stream_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  sync_fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .BURST_LEN(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // FIFO model: data appears the cycle after the read strobe.
  logic [DW-1:0] mem [256];
  int            wr_ptr  = 0;
  int            rd_ptr  = 0;
  int            ren_cnt = 0;
  logic [DW-1:0] fdat    = '0;

  assign bus.fifo_empty    = (wr_ptr == rd_ptr);
  assign bus.fifo_data_out = fdat;

  always @(posedge clk) begin
    if (bus.fifo_r_en) begin
      fdat    <= mem[rd_ptr[7:0]];
      rd_ptr  <= rd_ptr + 1;
      ren_cnt <= ren_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Scoreboard: acc_ptr indexes the next word the consumer must see.
  int            acc_ptr   = 0;
  int            burst_pos = 0;
  int            outst;
  logic [CW-1:0] xfer_exp  = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          exp_last;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      chk("rst_ren",   bus.fifo_r_en, 0);
      chk("rst_valid", bus.m_valid, 0);
      chk("rst_data",  bus.m_data, 0);
      chk("rst_last",  bus.m_last, 0);
      chk("rst_xfer",  bus.xfer_count, 0);
      chk("rst_busy",  bus.busy, 0);
      acc_ptr    = rd_ptr;
      burst_pos  = 0;
      xfer_exp   = '0;
      prev_stall = 1'b0;
    end else begin
      outst = rd_ptr - acc_ptr;
      if (bus.fifo_empty) chk("ren_while_empty", bus.fifo_r_en, 0);
      if (!bus.en) chk("ren_while_en_low", bus.fifo_r_en, 0);
      if (outst - int'(bus.m_valid && bus.m_ready) >= 2) chk("ren_when_full", bus.fifo_r_en, 0);
      chk("busy", bus.busy, outst != 0);
      chk("xfer_count", bus.xfer_count, xfer_exp);
      if (prev_stall) begin
        chk("stall_valid", bus.m_valid, 1);
        chk("stall_data", bus.m_data, prev_data);
      end
`ifdef SYNC_FIFO_RD_STREAM_LAST_EN
      exp_last = bus.m_valid && (burst_pos == BL - 1);
`else
      exp_last = 1'b0;
`endif
      chk("m_last", bus.m_last, exp_last);
      if (bus.m_valid && bus.m_ready) begin
        chk("word_was_popped", acc_ptr < rd_ptr, 1);
        chk("order", bus.m_data, mem[acc_ptr[7:0]]);
        acc_ptr   = acc_ptr + 1;
        xfer_exp  = xfer_exp + CW'(1);
        burst_pos = (burst_pos + 1) % BL;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while (acc_ptr != wr_ptr && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, acc_ptr, wr_ptr);
  endtask

  int r0;
  int a0;

  initial begin
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.m_ready = 1'b0;

    // Reset held with words waiting: nothing may be popped.
    repeat (2) @(negedge clk);
    push(8'h3A); push(8'h3B); push(8'h3C);
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Stalled consumer: buffer fills to two, then pops stop.
    repeat (4) @(negedge clk);
    #2;
    chk("fill_ren_cnt", ren_cnt, 2);
    chk("fill_valid", bus.m_valid, 1);
    chk("fill_head", bus.m_data, 8'h3A);
    // Reset mid-operation drops both buffered words.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.m_ready = 1'b1;
    drain("rst_drain");
    chk("rst_ren_total", ren_cnt, 3);
    chk("rst_xfer_after", bus.xfer_count, 1);

    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Basic order and throughput.
    @(negedge clk);
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    bus.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (i < 8) chk("tput_ren", bus.fifo_r_en, 1);
      if (i >= 2) chk("tput_valid", bus.m_valid, 1);
      @(negedge clk);
    end
    #2;
    chk("basic_xfer", bus.xfer_count, 8);
    chk("basic_busy", bus.busy, 0);
    chk("basic_valid", bus.m_valid, 0);

    // Backpressure with alternating ready.
    @(negedge clk);
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    bus.m_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && acc_ptr != wr_ptr; cyc++) begin
      @(negedge clk);
      bus.m_ready = ~bus.m_ready;
    end
    chk("bp_drained", acc_ptr, wr_ptr);
    bus.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("bp_xfer", bus.xfer_count, 16);

    // Empty boundary: a single word.
    repeat (2) @(negedge clk);
    r0 = ren_cnt;
    push(8'hA5);
    #2;
    chk("eb_ren", bus.fifo_r_en, 1);
    @(negedge clk); #2;
    chk("eb_valid_early", bus.m_valid, 0);
    chk("eb_ren_off", bus.fifo_r_en, 0);
    @(negedge clk); #2;
    chk("eb_valid", bus.m_valid, 1);
    chk("eb_data", bus.m_data, 8'hA5);
    @(negedge clk); #2;
    chk("eb_pulses", ren_cnt - r0, 1);
    chk("eb_valid_done", bus.m_valid, 0);

    // en gating right after a pop.
    @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    r0 = ren_cnt;
    a0 = acc_ptr;
    @(negedge clk);
    bus.en = 1'b1;
    #2;
    chk("eg_ren", bus.fifo_r_en, 1);
    @(negedge clk);
    bus.en = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    chk("eg_ren_stopped", ren_cnt - r0, 1);
    chk("eg_inflight_delivered", acc_ptr - a0, 1);
    chk("eg_busy", bus.busy, 0);
    @(negedge clk);
    bus.en = 1'b1;
    drain("eg_drain");
    chk("eg_ren_total", ren_cnt - r0, 4);
    @(negedge clk); #2;
    chk("final_xfer", bus.xfer_count, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
